pc_redirect_unit: RTL and testbench

- Owns the program counter and issues fetch requests to instruction memory over a valid/ready handshake.
- Consumes the EX-stage control-flow result: the branch decision from the branch comparator, plus JAL/JALR indications.
- On a taken branch or jump it redirects the PC, squashes wrong-path fetches for a fixed number of flush cycles, and raises a one-cycle trap on a misaligned target.
- Sits between the EX-stage branch comparator and the instruction-fetch stage.

---
 rtl/pc_redirect_unit.sv | 119 +++++++++++
 tb/tb_pc_redirect_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_unit.sv
// Program counter owner: issues fetches and redirects on EX-stage control flow.
// Squashes wrong-path fetches for FLUSH_CYCLES cycles and traps misaligned targets.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC     = 32'h0000_0100,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        fetch_ready,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_is_jal,
  input  logic        ex_is_jalr,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_rs1,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        misalign_trap,
  output logic [31:0] trap_tval
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        redir_q, redir_d;
  logic [31:0] rpc_q, rpc_d;
  logic        trap_q, trap_d;
  logic [31:0] tval_q, tval_d;

  logic        taken;
  logic [31:0] tgt;

  assign taken = ex_valid &
    (ex_is_jalr | ex_is_jal | (ex_is_branch & ex_branch_taken));

  // jalr wins over jal/branch; bit0 of a jalr target is always cleared
  assign tgt = ex_is_jalr ? ((ex_rs1 + ex_imm) & ~32'h1)
                          : (ex_pc + ex_imm);

  assign fetch_valid   = ~rst & (state_q == RUN) & ~stall;
  assign fetch_pc      = pc_q;
  assign flush         = (state_q == FLUSH);
  assign redirect      = redir_q;
  assign redirect_pc   = rpc_q;
  assign misalign_trap = trap_q;
  assign trap_tval     = tval_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    redir_d = 1'b0;
    rpc_d   = rpc_q;
    trap_d  = 1'b0;
    tval_d  = tval_q;
    unique case (state_q)
      RUN: begin
        if (taken) begin
          state_d = FLUSH;
          cnt_d   = CNT_INIT;
          if (tgt[1:0] == 2'b00) begin
            pc_d    = tgt;
            redir_d = 1'b1;
            rpc_d   = tgt;
          end else begin
            pc_d   = TRAP_VEC;
            trap_d = 1'b1;
            tval_d = tgt;
          end
        end else if (~stall & fetch_ready) begin
          pc_d = pc_q + 32'd4;
        end
      end
      FLUSH: begin
        if (cnt_q == 3'd0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= 3'd0;
      redir_q <= 1'b0;
      rpc_q   <= 32'h0;
      trap_q  <= 1'b0;
      tval_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      redir_q <= redir_d;
      rpc_q   <= rpc_d;
      trap_q  <= trap_d;
      tval_q  <= tval_d;
    end
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Bench for pc_redirect_unit: directed vectors, a cycle model and literal pins.
// The model counts remaining flush cycles instead of tracking an FSM.
module tb_pc_redirect_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] TVEC   = 32'h0000_0100;
  localparam int          NFL    = 2;

  logic        clk = 1'b0;
  logic        rst, stall, fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr;
  logic        ex_branch_taken;
  logic [31:0] ex_pc, ex_imm, ex_rs1;
  logic        redirect, flush, misalign_trap;
  logic [31:0] redirect_pc, trap_tval;

  int checks = 0;
  int errors = 0;

  pc_redirect_unit #(
    .RESET_PC(RST_PC), .TRAP_VEC(TVEC), .FLUSH_CYCLES(NFL)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .fetch_ready(fetch_ready), .fetch_valid(fetch_valid),
    .fetch_pc(fetch_pc), .ex_valid(ex_valid),
    .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal),
    .ex_is_jalr(ex_is_jalr), .ex_branch_taken(ex_branch_taken),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .flush(flush), .misalign_trap(misalign_trap),
    .trap_tval(trap_tval)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // model state
  bit          m_ok = 0;
  logic [31:0] m_pc, m_rpc, m_tval;
  int          m_left;
  bit          m_redir, m_trap;

  always @(posedge clk) begin
    logic [31:0] t;
    bit          hit;
    if (rst) begin
      m_ok = 1; m_pc = RST_PC; m_left = 0;
      m_redir = 0; m_trap = 0; m_rpc = 0; m_tval = 0;
    end else if (m_ok) begin
      m_redir = 0; m_trap = 0;
      hit = 0; t = 32'h0;
      if (ex_valid) begin
        if (ex_is_jalr) begin
          hit = 1; t = ex_rs1 + ex_imm; t[0] = 1'b0;
        end else if (ex_is_jal || (ex_is_branch && ex_branch_taken)) begin
          hit = 1; t = ex_pc + ex_imm;
        end
      end
      if (m_left > 0) begin
        m_left--;
      end else if (hit) begin
        m_left = NFL;
        if (t % 4 == 0) begin
          m_pc = t; m_rpc = t; m_redir = 1;
        end else begin
          m_pc = TVEC; m_tval = t; m_trap = 1;
        end
      end else if (!stall && fetch_ready) begin
        m_pc = m_pc + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("m_fetch_valid", 32'(fetch_valid),
          32'(!rst && m_left == 0 && !stall));
      chk("m_fetch_pc", fetch_pc, m_pc);
      chk("m_flush", 32'(flush), 32'(m_left > 0));
      chk("m_redirect", 32'(redirect), 32'(m_redir));
      chk("m_redirect_pc", redirect_pc, m_rpc);
      chk("m_trap", 32'(misalign_trap), 32'(m_trap));
      chk("m_tval", trap_tval, m_tval);
    end
  end

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic ex_clr();
    ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
    ex_branch_taken = 0; ex_pc = 0; ex_imm = 0; ex_rs1 = 0;
  endtask

  task automatic ex_set(input bit br, input bit tk, input bit jal,
                        input bit jalr, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [31:0] rs1);
    ex_valid = 1; ex_is_branch = br; ex_branch_taken = tk;
    ex_is_jal = jal; ex_is_jalr = jalr;
    ex_pc = pc; ex_imm = imm; ex_rs1 = rs1;
  endtask

  initial begin
    rst = 1; stall = 0; fetch_ready = 1;
    ex_clr();
    nxt(); nxt();
    chk("rst_pc", fetch_pc, 32'h0);
    chk("rst_fv", 32'(fetch_valid), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_redir", 32'(redirect), 32'h0);

    rst = 0; #1;
    chk("run_fv", 32'(fetch_valid), 32'h1);
    chk("seq0", fetch_pc, 32'h0);
    nxt(); chk("seq4", fetch_pc, 32'h4);
    nxt(); chk("seq8", fetch_pc, 32'h8);

    fetch_ready = 0;
    repeat (3) nxt();
    chk("hold_pc", fetch_pc, 32'h8);
    chk("hold_fv", 32'(fetch_valid), 32'h1);
    fetch_ready = 1; stall = 1;
    nxt(); nxt();
    chk("stall_pc", fetch_pc, 32'h8);
    chk("stall_fv", 32'(fetch_valid), 32'h0);
    stall = 0;
    nxt(); chk("seqC", fetch_pc, 32'hC);

    // taken branch back to 0x10
    ex_set(1, 1, 0, 0, 32'h20, 32'hFFFF_FFF0, 32'h0);
    nxt();
    chk("br_redir", 32'(redirect), 32'h1);
    chk("br_rpc", redirect_pc, 32'h10);
    chk("br_flush", 32'(flush), 32'h1);
    chk("br_fv", 32'(fetch_valid), 32'h0);
    // wrong-path jump during flush must be ignored
    ex_set(0, 0, 1, 0, 32'h200, 32'h40, 32'h0);
    nxt();
    chk("fl2_redir", 32'(redirect), 32'h0);
    chk("fl2_flush", 32'(flush), 32'h1);
    ex_clr();
    nxt();
    chk("res_flush", 32'(flush), 32'h0);
    chk("res_pc10", fetch_pc, 32'h10);
    nxt(); chk("res_pc14", fetch_pc, 32'h14);

    // not-taken branch
    ex_set(1, 0, 0, 0, 32'h14, 32'h100, 32'h0);
    nxt();
    chk("nt_redir", 32'(redirect), 32'h0);
    chk("nt_flush", 32'(flush), 32'h0);
    chk("nt_pc", fetch_pc, 32'h18);

    // jalr beats branch; target 0x102 is misaligned
    ex_set(1, 1, 0, 1, 32'h40, 32'h2, 32'h101);
    nxt(); ex_clr();
    chk("tr_trap", 32'(misalign_trap), 32'h1);
    chk("tr_redir", 32'(redirect), 32'h0);
    chk("tr_tval", trap_tval, 32'h102);
    chk("tr_pc", fetch_pc, 32'h100);
    nxt();
    chk("tr_pulse", 32'(misalign_trap), 32'h0);
    nxt();
    chk("tr_run", 32'(flush), 32'h0);
    chk("tr_pc2", fetch_pc, 32'h100);

    // jal wraps to 0
    ex_set(0, 0, 1, 0, 32'hFFFF_FFFC, 32'h4, 32'h0);
    nxt(); ex_clr();
    chk("jal_redir", 32'(redirect), 32'h1);
    chk("jal_rpc", redirect_pc, 32'h0);
    nxt(); nxt();

    // jump to last word, then PC increment wraps
    ex_set(0, 0, 1, 0, 32'h0, 32'hFFFF_FFFC, 32'h0);
    nxt(); ex_clr();
    nxt(); nxt();
    chk("top_pc", fetch_pc, 32'hFFFF_FFFC);
    nxt();
    chk("wrap_pc", fetch_pc, 32'h0);

    // taken under stall, then reset in second flush cycle
    stall = 1;
    ex_set(1, 1, 0, 0, 32'h0, 32'h80, 32'h0);
    nxt(); ex_clr(); stall = 0;
    chk("st_pc", fetch_pc, 32'h80);
    nxt();
    chk("st_fl2", 32'(flush), 32'h1);
    rst = 1;
    nxt();
    rst = 0; #1;
    chk("mid_pc", fetch_pc, RST_PC);
    chk("mid_flush", 32'(flush), 32'h0);
    chk("mid_fv", 32'(fetch_valid), 32'h1);
    nxt(); nxt();
    chk("post_pc", fetch_pc, 32'h8);

    repeat (2) nxt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
